legv8_control_sequencer: RTL and testbench

Multi-cycle control sequencer for the LEGv8 datapath. Latches the 32-bit instruction from the instruction ROM, decodes it, and drives the 25-bit datapath control word, the 64-bit constant, status-load and PC-select. Sits directly upstream of the datapath and consumes the datapath's 5-bit status. Each instruction takes two cycles: FETCH, then EXEC.

---
 rtl/legv8_control_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_legv8_control_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_sequencer.sv
// Two-cycle LEGv8 sequencer: latches the instruction in FETCH, decodes it in EXEC into the datapath control word.
// Outputs are combinational from state/IR/status (PS follows the live ALU zero); no backpressure, one instruction per two cycles.
module legv8_control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [4:0]  status,
  output logic [24:0] control_word,
  output logic [63:0] constant,
  output logic        SL,
  output logic [1:0]  PS,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic [4:0]  FS_AND = 5'b00000;
  localparam logic [4:0]  FS_ORR = 5'b00100;
  localparam logic [4:0]  FS_ADD = 5'b01000;
  localparam logic [4:0]  FS_SUB = 5'b01001;
  localparam logic [4:0]  FS_EOR = 5'b01100;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [24:0] CW_NOP = {5'd31, 5'd31, 5'd31, 10'd0};

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] ir;

  logic [4:0]  sa, sb, da, fs;
  logic        reg_write, mem_write, bsel, en_mem, en_alu, sl_dec;
  logic [1:0]  ps_dec;
  logic [63:0] k;
  logic        known, r_type, i_type;

  logic [63:0] imm12_zx, mem_off, cb_off, b_off;

  assign imm12_zx = {52'd0, ir[21:10]};
  assign mem_off  = {{55{ir[20]}}, ir[20:12]};
  assign cb_off   = {{43{ir[23]}}, ir[23:5], 2'b00};
  assign b_off    = {{36{ir[25]}}, ir[25:0], 2'b00};

  // ARM condition table over the registered flags {V,C,N,Z}
  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] flags);
    logic v, c, n, z;
    {v, c, n, z} = flags;
    case (cond)
      4'h0:    cond_met = z;
      4'h1:    cond_met = !z;
      4'h2:    cond_met = c;
      4'h3:    cond_met = !c;
      4'h4:    cond_met = n;
      4'h5:    cond_met = !n;
      4'h6:    cond_met = v;
      4'h7:    cond_met = !v;
      4'h8:    cond_met = c && !z;
      4'h9:    cond_met = !(c && !z);
      4'hA:    cond_met = (n == v);
      4'hB:    cond_met = (n != v);
      4'hC:    cond_met = !z && (n == v);
      4'hD:    cond_met = !(!z && (n == v));
      default: cond_met = 1'b1;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) ir <= instruction;
      if (state == EXEC && known) retired <= retired + 32'd1;
    end
  end

  // Longest opcode wins: 11-bit, then 10-bit, then 8-bit, then 6-bit
  always_comb begin
    sa = 5'd31; sb = 5'd31; da = 5'd31; fs = FS_AND;
    reg_write = 1'b0; mem_write = 1'b0; bsel = 1'b0;
    en_mem = 1'b0; en_alu = 1'b0; sl_dec = 1'b0;
    ps_dec = 2'b00; k = '0;
    known = 1'b1; r_type = 1'b0; i_type = 1'b0;
    case (ir[31:21])
      OP_ADD:  begin r_type = 1'b1; fs = FS_ADD; end
      OP_SUB:  begin r_type = 1'b1; fs = FS_SUB; end
      OP_AND:  begin r_type = 1'b1; fs = FS_AND; end
      OP_ORR:  begin r_type = 1'b1; fs = FS_ORR; end
      OP_EOR:  begin r_type = 1'b1; fs = FS_EOR; end
      OP_ADDS: begin r_type = 1'b1; fs = FS_ADD; sl_dec = 1'b1; end
      OP_SUBS: begin r_type = 1'b1; fs = FS_SUB; sl_dec = 1'b1; end
      OP_LDUR: begin
        sa = ir[9:5]; da = ir[4:0]; fs = FS_ADD; bsel = 1'b1;
        reg_write = 1'b1; en_mem = 1'b1; k = mem_off; ps_dec = 2'b01;
      end
      OP_STUR: begin
        sa = ir[9:5]; sb = ir[4:0]; fs = FS_ADD; bsel = 1'b1;
        mem_write = 1'b1; k = mem_off; ps_dec = 2'b01;
      end
      OP_BR: begin sa = ir[9:5]; ps_dec = 2'b11; end
      default: begin
        case (ir[31:22])
          OP_ADDI: begin i_type = 1'b1; fs = FS_ADD; end
          OP_SUBI: begin i_type = 1'b1; fs = FS_SUB; end
          OP_ANDI: begin i_type = 1'b1; fs = FS_AND; end
          OP_ORRI: begin i_type = 1'b1; fs = FS_ORR; end
          default: begin
            case (ir[31:24])
              // ir[24] separates CBNZ from CBZ, so XOR with live zero gives "taken"
              OP_CBZ, OP_CBNZ: begin
                sa = ir[4:0]; fs = FS_ADD; k = cb_off;
                ps_dec = (status[0] ^ ir[24]) ? 2'b10 : 2'b01;
              end
              OP_BCOND: begin
                k = cb_off;
                ps_dec = cond_met(ir[3:0], status[4:1]) ? 2'b10 : 2'b01;
              end
              default: begin
                if (ir[31:26] == OP_B) begin
                  k = b_off; ps_dec = 2'b10;
                end else begin
                  known = 1'b0;
                end
              end
            endcase
          end
        endcase
      end
    endcase
    if (r_type || i_type) begin
      sa = ir[9:5]; da = ir[4:0]; reg_write = 1'b1; en_alu = 1'b1; ps_dec = 2'b01;
    end
    if (r_type) sb = ir[20:16];
    if (i_type) begin
      bsel = 1'b1; k = imm12_zx;
    end
  end

  always_comb begin
    state_nxt    = state;
    control_word = CW_NOP;
    constant     = '0;
    SL           = 1'b0;
    PS           = 2'b00;
    case (state)
      FETCH: state_nxt = EXEC;
      EXEC: begin
        if (known) begin
          state_nxt    = FETCH;
          control_word = {sa, sb, da, reg_write, mem_write, fs, bsel, en_mem, en_alu};
          constant     = k;
          SL           = sl_dec;
          PS           = ps_dec;
        end else begin
          state_nxt = HALT;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
    // Suppress any write or PC move during the reset cycle itself
    if (reset) begin
      control_word = CW_NOP;
      constant     = '0;
      SL           = 1'b0;
      PS           = 2'b00;
    end
  end

  assign halted = (state == HALT) && !reset;

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// Bench for legv8_control_sequencer: mnemonic-level reference model checked every cycle, plus hand-computed literals.
module tb_legv8_control_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [24:0] control_word;
  logic [63:0] constant;
  logic        SL;
  logic [1:0]  PS;
  logic        halted;
  logic [31:0] retired;

  always #5 clock = ~clock;

  legv8_control_sequencer dut (
    .clock(clock), .reset(reset), .instruction(instruction), .status(status),
    .control_word(control_word), .constant(constant), .SL(SL), .PS(PS),
    .halted(halted), .retired(retired)
  );

  localparam logic [24:0] NOP = 25'h1FFFC00;

  typedef enum {M_NONE, M_ADD, M_SUB, M_AND, M_ORR, M_EOR, M_ADDS, M_SUBS,
                M_ADDI, M_SUBI, M_ANDI, M_ORRI, M_LDUR, M_STUR, M_BR,
                M_CBZ, M_CBNZ, M_BCOND, M_B} mn_t;

  typedef struct packed {
    logic        known;
    logic [24:0] cw;
    logic [63:0] k;
    logic        sl;
    logic [1:0]  ps;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  int          m_phase = 0;   // 0 fetch, 1 exec, 2 halted
  logic [31:0] m_ir = '0;
  logic [31:0] m_retired = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mn_t mnemonic(input logic [31:0] ir);
    mn_t m;
    m = M_NONE;
    case (ir[31:21])
      11'b10001011000: m = M_ADD;
      11'b11001011000: m = M_SUB;
      11'b10001010000: m = M_AND;
      11'b10101010000: m = M_ORR;
      11'b11001010000: m = M_EOR;
      11'b10101011000: m = M_ADDS;
      11'b11101011000: m = M_SUBS;
      11'b11111000010: m = M_LDUR;
      11'b11111000000: m = M_STUR;
      11'b11010110000: m = M_BR;
      default: ;
    endcase
    if (m == M_NONE)
      case (ir[31:22])
        10'b1001000100: m = M_ADDI;
        10'b1101000100: m = M_SUBI;
        10'b1001001000: m = M_ANDI;
        10'b1011001000: m = M_ORRI;
        default: ;
      endcase
    if (m == M_NONE)
      case (ir[31:24])
        8'b10110100: m = M_CBZ;
        8'b10110101: m = M_CBNZ;
        8'b01010100: m = M_BCOND;
        default: ;
      endcase
    if (m == M_NONE && ir[31:26] == 6'b000101) m = M_B;
    return m;
  endfunction

  function automatic exp_t predict(input logic [31:0] ir, input logic [4:0] st);
    exp_t e;
    mn_t m;
    logic [4:0] sa, sb, da, fs;
    logic rw, mw, bs, em, ea, sl, z, n, c, v, hold;
    logic [1:0] ps;
    logic signed [8:0]  s9;
    logic signed [18:0] s19;
    logic signed [25:0] s26;
    longint ks;
    logic [63:0] k;
    m = mnemonic(ir);
    sa = 5'd31; sb = 5'd31; da = 5'd31; fs = 5'd0;
    rw = 0; mw = 0; bs = 0; em = 0; ea = 0; sl = 0; ps = 2'd0; k = '0;
    s9 = ir[20:12]; s19 = ir[23:5]; s26 = ir[25:0];
    z = st[1]; n = st[2]; c = st[3]; v = st[4];
    case (m)
      M_ADD, M_ADDS, M_ADDI, M_LDUR, M_STUR, M_CBZ, M_CBNZ: fs = 5'b01000;
      M_SUB, M_SUBS, M_SUBI: fs = 5'b01001;
      M_ORR, M_ORRI:         fs = 5'b00100;
      M_EOR:                 fs = 5'b01100;
      default:               fs = 5'b00000;
    endcase
    case (m)
      M_ADD, M_SUB, M_AND, M_ORR, M_EOR, M_ADDS, M_SUBS: begin
        sa = ir[9:5]; sb = ir[20:16]; da = ir[4:0]; rw = 1; ea = 1; ps = 2'd1;
        sl = (m == M_ADDS) || (m == M_SUBS);
      end
      M_ADDI, M_SUBI, M_ANDI, M_ORRI: begin
        sa = ir[9:5]; da = ir[4:0]; rw = 1; ea = 1; bs = 1; ps = 2'd1;
        k = 64'(ir[21:10]);
      end
      M_LDUR: begin
        sa = ir[9:5]; da = ir[4:0]; rw = 1; em = 1; bs = 1; ps = 2'd1;
        ks = s9; k = ks;
      end
      M_STUR: begin
        sa = ir[9:5]; sb = ir[4:0]; mw = 1; bs = 1; ps = 2'd1;
        ks = s9; k = ks;
      end
      M_B: begin ks = s26; k = ks * 4; ps = 2'd2; end
      M_CBZ, M_CBNZ: begin
        sa = ir[4:0]; ks = s19; k = ks * 4;
        ps = (((m == M_CBZ) ? 1'b1 : 1'b0) == st[0]) ? 2'd2 : 2'd1;
      end
      M_BCOND: begin
        ks = s19; k = ks * 4;
        // base test from cond[3:1], inverted by cond[0] except for 0xF
        case (ir[3:1])
          3'd0: hold = z;
          3'd1: hold = c;
          3'd2: hold = n;
          3'd3: hold = v;
          3'd4: hold = c && !z;
          3'd5: hold = (n == v);
          3'd6: hold = (n == v) && !z;
          default: hold = 1'b1;
        endcase
        if (ir[0] && ir[3:0] != 4'hF) hold = !hold;
        ps = hold ? 2'd2 : 2'd1;
      end
      M_BR: begin sa = ir[9:5]; ps = 2'd3; end
      default: ;
    endcase
    e.known = (m != M_NONE);
    e.cw = {sa, sb, da, rw, mw, fs, bs, em, ea};
    e.k = k; e.sl = sl; e.ps = ps;
    return e;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_phase <= 0; m_ir <= '0; m_retired <= '0;
    end else if (m_phase == 0) begin
      m_ir <= instruction; m_phase <= 1;
    end else if (m_phase == 1) begin
      if (mnemonic(m_ir) != M_NONE) begin
        m_retired <= m_retired + 32'd1; m_phase <= 0;
      end else begin
        m_phase <= 2;
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    e = predict(m_ir, status);
    if (reset || m_phase != 1 || !e.known) begin
      e.cw = NOP; e.k = '0; e.sl = 1'b0; e.ps = 2'd0;
    end
    check("cycle_cw", 64'(control_word), 64'(e.cw));
    check("cycle_const", constant, e.k);
    check("cycle_sl", 64'(SL), 64'(e.sl));
    check("cycle_ps", 64'(PS), 64'(e.ps));
    check("cycle_halted", 64'(halted), 64'((m_phase == 2) && !reset));
    check("cycle_retired", 64'(retired), 64'(m_retired));
  end

  // Enter just after a FETCH edge; return at the EXEC-cycle negedge
  task automatic issue(input logic [31:0] ins, input logic [4:0] st);
    instruction = ins; status = st;
    @(negedge clock);
    check("fetch_ps", 64'(PS), 64'd0);
    @(posedge clock); #1;
    instruction = ~ins;
    @(negedge clock);
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  logic [31:0] sweep [10] = '{32'h8A030041, 32'hAA030041, 32'hCA030041, 32'hCB030041,
                              32'hAB030041, 32'hD1001441, 32'h92001441, 32'hB2001441,
                              32'h17FFFFFF, 32'hB5FFFFE9};

  initial begin
    reset = 1'b1; instruction = '0; status = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cw", 64'(control_word), 64'(NOP));
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    reset = 1'b0;

    issue(32'h8B020023, 5'd0);
    check("add_sa", 64'(control_word[24:20]), 64'd1);
    check("add_sb", 64'(control_word[19:15]), 64'd2);
    check("add_da", 64'(control_word[14:10]), 64'd3);
    check("add_rw", 64'(control_word[9]), 64'd1);
    check("add_fs", 64'(control_word[7:3]), 64'b01000);
    check("add_en_alu", 64'(control_word[0]), 64'd1);
    check("add_ps", 64'(PS), 64'd1);
    check("add_sl", 64'(SL), 64'd0);
    step();
    check("add_retired", 64'(retired), 64'd1);

    issue(32'h913FFFE5, 5'd0);
    check("addi_bsel", 64'(control_word[2]), 64'd1);
    check("addi_const", constant, 64'h0000000000000FFF);
    check("addi_da", 64'(control_word[14:10]), 64'd5);
    step();

    issue(32'hEB020020, 5'b10110);
    check("subs_sl", 64'(SL), 64'd1);
    check("subs_fs", 64'(control_word[7:3]), 64'b01001);
    step();

    issue(32'hF81F80C4, 5'd0);
    check("stur_mw", 64'(control_word[8]), 64'd1);
    check("stur_rw", 64'(control_word[9]), 64'd0);
    check("stur_const", constant, 64'hFFFFFFFFFFFFFFF8);
    step();

    issue(32'hF85F80C7, 5'd0);
    check("ldur_en_mem", 64'(control_word[1]), 64'd1);
    check("ldur_da", 64'(control_word[14:10]), 64'd7);
    step();

    issue(32'hB4FFFFE9, 5'b00001);
    check("cbz_taken_ps", 64'(PS), 64'd2);
    check("cbz_const", constant, 64'hFFFFFFFFFFFFFFFC);
    #1 status = 5'b00000;
    #1 check("cbz_live_ps", 64'(PS), 64'd1);
    step();

    issue(32'hB4FFFFE9, 5'd0);
    check("cbz_nottaken_ps", 64'(PS), 64'd1);
    step();

    issue(32'h54000040, 5'b00010);
    check("beq_ps", 64'(PS), 64'd2);
    check("beq_const", constant, 64'd8);
    step();

    issue(32'h54000041, 5'b00010);
    check("bne_ps", 64'(PS), 64'd1);
    step();

    issue(32'h14000003, 5'd0);
    check("b_const", constant, 64'd12);
    check("b_ps", 64'(PS), 64'd2);
    step();

    issue(32'hD61F03C0, 5'd0);
    check("br_ps", 64'(PS), 64'd3);
    check("br_sa", 64'(control_word[24:20]), 64'd30);
    step();

    foreach (sweep[i]) begin
      issue(sweep[i], 5'd0);
      step();
    end

    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f += 3) begin
        logic [31:0] ins;
        logic [3:0]  fl;
        ins = 32'h54000040 | 32'(c);
        fl = 4'(f);
        issue(ins, {fl, 1'b0});
        step();
      end
    end

    issue(32'hF81F80C4, 5'd0);
    #1 reset = 1'b1;
    #1 check("rst_exec_mw", 64'(control_word[8]), 64'd0);
    check("rst_exec_ps", 64'(PS), 64'd0);
    step();
    reset = 1'b0;
    check("rst_exec_retired", 64'(retired), 64'd0);

    issue(32'h8B020023, 5'd0);
    step();
    check("post_rst_retired", 64'(retired), 64'd1);

    issue(32'h00000000, 5'd0);
    check("bad_cw", 64'(control_word), 64'(NOP));
    check("bad_ps", 64'(PS), 64'd0);
    step();
    check("halt_flag", 64'(halted), 64'd1);
    repeat (4) step();
    check("halt_hold", 64'(halted), 64'd1);
    check("halt_ps", 64'(PS), 64'd0);
    check("halt_retired", 64'(retired), 64'd1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("unhalt", 64'(halted), 64'd0);
    issue(32'h8B020023, 5'd0);
    step();
    check("final_retired", 64'(retired), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
